// File: rtl/msrv32_wb_arbiter.sv
// Write-back arbiter: merges pipeline (A) and long-latency (B) results into
// the register file write port, with read forwarding and B pending flags.
module msrv32_wb_arbiter #(
   parameter int FIFO_DEPTH = 4,
   parameter int STARVE_MAX = 8
) (
   input  logic        ms_riscv32_mp_clk_in,
   input  logic        ms_riscv32_mp_rst_in,
   input  logic        a_valid_in,
   input  logic [4:0]  a_rd_addr_in,
   input  logic [31:0] a_data_in,
   input  logic        b_valid_in,
   output logic        b_ready_out,
   input  logic [4:0]  b_rd_addr_in,
   input  logic [31:0] b_data_in,
   output logic        wr_en_out,
   output logic [4:0]  rd_addr_out,
   output logic [31:0] rd_out,
   input  logic [4:0]  rs1_addr_in,
   input  logic [4:0]  rs2_addr_in,
   input  logic [31:0] rs1_rf_in,
   input  logic [31:0] rs2_rf_in,
   output logic [31:0] rs1_out,
   output logic [31:0] rs2_out,
   output logic        rs1_pending_out,
   output logic        rs2_pending_out,
   output logic        stall_req_out
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int SW = $clog2(STARVE_MAX + 1);

   logic [4:0]    fifo_rd_q   [FIFO_DEPTH];
   logic [4:0]    fifo_rd_d   [FIFO_DEPTH];
   logic [31:0]   fifo_data_q [FIFO_DEPTH];
   logic [31:0]   fifo_data_d [FIFO_DEPTH];
   logic [AW-1:0] wptr_q, wptr_d;
   logic [AW-1:0] rptr_q, rptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [SW-1:0] starve_q, starve_d;
   logic          wr_en_q, wr_en_d;
   logic [4:0]    rd_addr_q, rd_addr_d;
   logic [31:0]   rd_q, rd_d;

   logic          a_win, empty, deq, enq;
   logic [AW-1:0] off;
   logic          p1, p2;

   assign b_ready_out = !ms_riscv32_mp_rst_in
                        & (count_q < CW'(FIFO_DEPTH));

   always_comb begin
      a_win     = a_valid_in & (a_rd_addr_in != 5'd0);
      empty     = (count_q == '0);
      deq       = !a_win & !empty;
      enq       = b_valid_in & b_ready_out & (b_rd_addr_in != 5'd0);
      wr_en_d   = 1'b0;
      rd_addr_d = rd_addr_q;
      rd_d      = rd_q;
      if (a_win) begin
         wr_en_d   = 1'b1;
         rd_addr_d = a_rd_addr_in;
         rd_d      = a_data_in;
      end else if (deq) begin
         wr_en_d   = 1'b1;
         rd_addr_d = fifo_rd_q[rptr_q];
         rd_d      = fifo_data_q[rptr_q];
      end
      fifo_rd_d   = fifo_rd_q;
      fifo_data_d = fifo_data_q;
      if (enq) begin
         fifo_rd_d[wptr_q]   = b_rd_addr_in;
         fifo_data_d[wptr_q] = b_data_in;
      end
      wptr_d  = enq ? wptr_q + AW'(1) : wptr_q;
      rptr_d  = deq ? rptr_q + AW'(1) : rptr_q;
      count_d = count_q;
      if (enq && !deq)
         count_d = count_q + CW'(1);
      else if (deq && !enq)
         count_d = count_q - CW'(1);
      // Starvation only accrues while A holds off a waiting entry
      starve_d = starve_q;
      if (empty || deq)
         starve_d = '0;
      else if (a_win && starve_q != SW'(STARVE_MAX))
         starve_d = starve_q + SW'(1);
   end

   always_comb begin
      p1  = 1'b0;
      p2  = 1'b0;
      off = '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         off = AW'(i) - rptr_q;
         if ({1'b0, off} < count_q) begin
            if (fifo_rd_q[i] == rs1_addr_in) p1 = 1'b1;
            if (fifo_rd_q[i] == rs2_addr_in) p2 = 1'b1;
         end
      end
      rs1_pending_out = p1 & (rs1_addr_in != 5'd0);
      rs2_pending_out = p2 & (rs2_addr_in != 5'd0);
      rs1_out = (wr_en_q && rd_addr_q == rs1_addr_in
                 && rs1_addr_in != 5'd0) ? rd_q : rs1_rf_in;
      rs2_out = (wr_en_q && rd_addr_q == rs2_addr_in
                 && rs2_addr_in != 5'd0) ? rd_q : rs2_rf_in;
   end

   assign stall_req_out = (starve_q >= SW'(STARVE_MAX));
   assign wr_en_out     = wr_en_q;
   assign rd_addr_out   = rd_addr_q;
   assign rd_out        = rd_q;

   always_ff @(posedge ms_riscv32_mp_clk_in) begin
      fifo_rd_q   <= fifo_rd_d;
      fifo_data_q <= fifo_data_d;
   end

   always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
      if (ms_riscv32_mp_rst_in) begin
         wptr_q    <= '0;
         rptr_q    <= '0;
         count_q   <= '0;
         starve_q  <= '0;
         wr_en_q   <= 1'b0;
         rd_addr_q <= '0;
         rd_q      <= '0;
      end else begin
         wptr_q    <= wptr_d;
         rptr_q    <= rptr_d;
         count_q   <= count_d;
         starve_q  <= starve_d;
         wr_en_q   <= wr_en_d;
         rd_addr_q <= rd_addr_d;
         rd_q      <= rd_d;
      end
   end

endmodule

// File: tb/tb_msrv32_wb_arbiter.sv
// Scoreboard bench for msrv32_wb_arbiter: a reference model predicts each
// register file write, pending flags, forwarding and flow-control outputs.
module tb_msrv32_wb_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        a_valid = 1'b0;
   logic [4:0]  a_rd = '0;
   logic [31:0] a_data = '0;
   logic        b_valid = 1'b0;
   logic        b_ready;
   logic [4:0]  b_rd = '0;
   logic [31:0] b_data = '0;
   logic        wr_en;
   logic [4:0]  rd_addr;
   logic [31:0] rd;
   logic [4:0]  rs1_addr = '0;
   logic [4:0]  rs2_addr = '0;
   logic [31:0] rs1_rf = '0;
   logic [31:0] rs2_rf = '0;
   logic [31:0] rs1_o, rs2_o;
   logic        rs1_p, rs2_p;
   logic        stall;

   int total = 0;
   int bad   = 0;

   logic [36:0] mq[$];
   logic [36:0] expq[$];
   logic        m_wr = 1'b0;
   logic [4:0]  m_addr = '0;
   logic [31:0] m_data = '0;
   int          m_starve = 0;

   always #5 clk = ~clk;

   msrv32_wb_arbiter dut (
      .ms_riscv32_mp_clk_in (clk),
      .ms_riscv32_mp_rst_in (rst),
      .a_valid_in           (a_valid),
      .a_rd_addr_in         (a_rd),
      .a_data_in            (a_data),
      .b_valid_in           (b_valid),
      .b_ready_out          (b_ready),
      .b_rd_addr_in         (b_rd),
      .b_data_in            (b_data),
      .wr_en_out            (wr_en),
      .rd_addr_out          (rd_addr),
      .rd_out               (rd),
      .rs1_addr_in          (rs1_addr),
      .rs2_addr_in          (rs2_addr),
      .rs1_rf_in            (rs1_rf),
      .rs2_rf_in            (rs2_rf),
      .rs1_out              (rs1_o),
      .rs2_out              (rs2_o),
      .rs1_pending_out      (rs1_p),
      .rs2_pending_out      (rs2_p),
      .stall_req_out        (stall)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: register file write chosen at each edge
   always @(posedge clk) begin
      logic ready, empty, aw, dq;
      logic [36:0] e;
      if (rst) begin
         mq.delete();
         expq.delete();
         m_wr = 1'b0; m_addr = '0; m_data = '0; m_starve = 0;
      end else begin
         ready = (mq.size() < 4);
         empty = (mq.size() == 0);
         aw    = a_valid && a_rd != 5'd0;
         dq    = 1'b0;
         m_wr  = 1'b0;
         if (aw) begin
            m_wr = 1'b1; m_addr = a_rd; m_data = a_data;
         end else if (!empty) begin
            e = mq.pop_front();
            dq = 1'b1;
            m_wr = 1'b1; m_addr = e[36:32]; m_data = e[31:0];
         end
         if (m_wr) expq.push_back({m_addr, m_data});
         if (empty || dq) m_starve = 0;
         else if (aw && m_starve < 8) m_starve++;
         if (b_valid && ready && b_rd != 5'd0)
            mq.push_back({b_rd, b_data});
      end
   end

   always @(negedge clk) begin
      logic [36:0] e;
      logic p1, p2;
      if (!rst) begin
         chk("wr_en", {31'd0, wr_en}, {31'd0, expq.size() != 0});
         if (wr_en && expq.size() != 0) begin
            e = expq.pop_front();
            chk("rd_addr", {27'd0, rd_addr}, {27'd0, e[36:32]});
            chk("rd_data", rd, e[31:0]);
         end
         chk("b_ready", {31'd0, b_ready}, {31'd0, mq.size() < 4});
         chk("stall", {31'd0, stall}, {31'd0, m_starve >= 8});
         p1 = 1'b0; p2 = 1'b0;
         foreach (mq[i]) begin
            if (mq[i][36:32] == rs1_addr) p1 = 1'b1;
            if (mq[i][36:32] == rs2_addr) p2 = 1'b1;
         end
         chk("rs1_pend", {31'd0, rs1_p}, {31'd0, p1 && rs1_addr != 0});
         chk("rs2_pend", {31'd0, rs2_p}, {31'd0, p2 && rs2_addr != 0});
         chk("rs1_fwd", rs1_o,
             (m_wr && m_addr == rs1_addr && rs1_addr != 0) ? m_data : rs1_rf);
         chk("rs2_fwd", rs2_o,
             (m_wr && m_addr == rs2_addr && rs2_addr != 0) ? m_data : rs2_rf);
      end
   end

   task automatic drive(input logic av, input logic [4:0] aa,
                        input logic [31:0] ad, input logic bv,
                        input logic [4:0] ba, input logic [31:0] bd);
      a_valid = av; a_rd = aa; a_data = ad;
      b_valid = bv; b_rd = ba; b_data = bd;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      #2;
      chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
      chk("rst_rd", rd, 32'd0);
      chk("rst_b_ready", {31'd0, b_ready}, 32'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      idle(2);

      // single A write
      drive(1, 5, 32'h0000_1234, 0, 0, 0);
      idle(3);

      // A and B together, B pending visible in between
      rs1_addr = 5'd4;
      drive(1, 3, 32'hA, 1, 4, 32'hB);
      a_valid = 1'b0; b_valid = 1'b0;
      #1 chk("pend_x4", {31'd0, rs1_p}, 32'd1);
      idle(3);
      rs1_addr = 5'd0;

      // starvation: A every cycle while B fills the FIFO
      for (int i = 0; i < 12; i++)
         drive(1, 1, 32'h100 + i, i < 5, 5'(10 + i), 32'hB0 + i);
      chk("stall_set", {31'd0, stall}, 32'd1);
      chk("full", {31'd0, b_ready}, 32'd0);
      idle(6);

      // x0 on both ports
      drive(1, 0, 32'h5555, 1, 0, 32'h6666);
      idle(2);
      chk("x0_ready", {31'd0, b_ready}, 32'd1);

      // forwarding
      drive(1, 7, 32'hDEAD_BEEF, 0, 0, 0);
      rs1_addr = 5'd7; rs1_rf = 32'd0;
      rs2_addr = 5'd0; rs2_rf = 32'h0000_5A5A;
      #1;
      chk("fwd_rs1", rs1_o, 32'hDEAD_BEEF);
      chk("fwd_rs2", rs2_o, 32'h0000_5A5A);
      idle(2);

      // random traffic
      for (int i = 0; i < 300; i++) begin
         rs1_addr = 5'($urandom_range(0, 7));
         rs2_addr = 5'($urandom_range(0, 7));
         rs1_rf = $urandom; rs2_rf = $urandom;
         drive($urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)), $urandom,
               $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom);
      end
      idle(8);

      // async reset with two entries queued
      rs1_addr = 5'd21; rs2_addr = 5'd22;
      drive(1, 1, 32'h1, 1, 21, 32'h21);
      drive(1, 1, 32'h2, 1, 22, 32'h22);
      a_valid = 1'b0; b_valid = 1'b0;
      rst = 1'b1;
      #1;
      mq.delete(); expq.delete();
      m_wr = 1'b0; m_addr = '0; m_data = '0; m_starve = 0;
      chk("arst_wr_en", {31'd0, wr_en}, 32'd0);
      chk("arst_rd_addr", {27'd0, rd_addr}, 32'd0);
      chk("arst_rd", rd, 32'd0);
      chk("arst_pend", {30'd0, rs1_p, rs2_p}, 32'd0);
      chk("arst_b_ready", {31'd0, b_ready}, 32'd0);
      #1 rst = 1'b0;
      idle(5);
      chk("post_rst_ready", {31'd0, b_ready}, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
